// File: rtl/alu_operand_select_pipe.sv
// alu_operand_select_pipe
//   Picks one of NUM_SRC operand sources, registers the result and hands it to
//   the ALU stage over a valid/ready handshake. A main register plus one skid
//   register give full throughput while in_ready stays a pure register output.
//   Out-of-range selects yield zero data with an error flag. A saturating
//   counter tracks accepted bad selects for debug.
//
//   Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both high in the cycle before it. On the input side, accept = in_valid &
//   in_ready. On the output side, pop = out_valid & out_ready. A producer holds
//   its data stable while valid is high and ready is low. Ready never depends
//   combinationally on the partner's valid.
//
//   Occupancy states:
//     ST_EMPTY : nothing buffered.
//     ST_ONE   : main register holds the head entry.
//     ST_TWO   : main holds the head, skid holds the next entry; in_ready = 0.
//   flush overrides every transition and forces ST_EMPTY. An entry accepted in
//   the same cycle as flush is discarded, but it still counts as a bad select
//   in sel_err_cnt.
//
//   SEL_W must be >= clog2(NUM_SRC). Every select code that does not match a
//   source index is out of range. When NUM_SRC = 2**SEL_W, every code is in
//   range and out_sel_err is never set.

module alu_operand_select_pipe #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_sel_err,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               sel_err_cnt,
   output logic [1:0]               state_dbg
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_nxt;

   logic               in_ready_q;

   logic [WIDTH-1:0]   entry_data;
   logic               entry_err;

   logic [WIDTH-1:0]   main_data_q;
   logic               main_err_q;
   logic [WIDTH-1:0]   skid_data_q;
   logic               skid_err_q;

   logic [7:0]         err_cnt_q;

   logic               accept;
   logic               pop;
   logic               load_main_new;
   logic               load_main_skid;
   logic               load_skid;

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------
   assign accept    = in_valid & in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign pop       = out_valid & out_ready;

   // ------------------------------------------------------------------
   // Entry construction
   // ------------------------------------------------------------------

   // Build the candidate entry: the matching source, or zero plus error when
   // no source index matches the select.
   always_comb begin
      entry_data = '0;
      entry_err  = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            entry_data = in_data[k*WIDTH +: WIDTH];
            entry_err  = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Occupancy FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic. flush wins over any accept or pop in the same cycle.
   always_comb begin
      state_nxt = state_q;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) state_nxt = ST_ONE;
            end
            ST_ONE: begin
               if (accept && !pop)      state_nxt = ST_TWO;
               else if (!accept && pop) state_nxt = ST_EMPTY;
            end
            ST_TWO: begin
               if (pop) state_nxt = ST_ONE;
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Output/control decode. This block produces the datapath load strobes
   // for the current state. A flushed cycle loads nothing.
   always_comb begin
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (!flush) begin
         case (state_q)
            ST_EMPTY: begin
               load_main_new = accept;
            end
            ST_ONE: begin
               load_main_new = accept & pop;
               load_skid     = accept & ~pop;
            end
            ST_TWO: begin
               load_main_skid = pop;
            end
            default: begin
               load_main_new  = 1'b0;
               load_main_skid = 1'b0;
               load_skid      = 1'b0;
            end
         endcase
      end
   end

   // in_ready follows the next state, so it stays a flop with no path from
   // out_ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= (state_nxt != ST_TWO);
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------

   // Main (head) register: loads a fresh entry or promotes the skid entry.
   // It holds its value otherwise, which keeps out_* stable while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_data_q <= '0;
         main_err_q  <= 1'b0;
      end else if (load_main_new) begin
         main_data_q <= entry_data;
         main_err_q  <= entry_err;
      end else if (load_main_skid) begin
         main_data_q <= skid_data_q;
         main_err_q  <= skid_err_q;
      end
   end

   // Skid register: catches the entry accepted while the head is stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else if (load_skid) begin
         skid_data_q <= entry_data;
         skid_err_q  <= entry_err;
      end
   end

   // ------------------------------------------------------------------
   // Debug error counter
   // ------------------------------------------------------------------

   // Count accepted bad selects, including those discarded by flush. The
   // counter saturates at 255 and only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= 8'd0;
      end else if (accept && entry_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready    = in_ready_q;
   assign out_data    = main_data_q;
   assign out_sel_err = main_err_q;
   assign sel_err_cnt = err_cnt_q;
   assign state_dbg   = state_q;

endmodule
